// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//
// Drives one shared external 4-bit adder to add or subtract WIDTH-bit operands.
// Each clock handles one nibble, starting with the least significant nibble.
// The carry is held in a register and passed from one nibble to the next.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             request, sampled only while idle
//   sub               0: a + b + c_in, 1: a - b (c_in ignored)
//   a, b, c_in        operands, captured on an accepted start
//   busy              operation in progress
//   done              one-cycle pulse; sum/c_out/ovf valid from this cycle
//   sum, c_out, ovf   result, final carry (sub: 1 = no borrow), signed overflow
//   add_a/b/cin       drive to the external adder (zero while idle)
//   add_s, add_cout   combinational result from the external adder

module nibble_serial_add_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_s,
   input  logic             add_cout
);

   localparam int unsigned NIB   = WIDTH / 4;
   localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

   if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_width_check
      $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
   end

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;        // already inverted for subtraction
   logic             carry_q;
   logic [IDX_W-1:0] idx_q;
   logic [WIDTH-1:0] sum_q;
   logic             c_out_q;
   logic             ovf_q;
   logic             done_q;
   logic             last;

   assign last = (state_q == StRun) && (idx_q == IDX_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (last)  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      busy    = (state_q == StRun);
      done    = done_q;
      sum     = sum_q;
      c_out   = c_out_q;
      ovf     = ovf_q;
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state_q == StRun) begin
         add_a   = a_q[4*idx_q +: 4];
         add_b   = b_q[4*idx_q +: 4];
         add_cin = carry_q;
      end
   end

   // Operand capture and nibble-serial datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == StIdle) begin
            if (start) begin
               a_q     <= a;
               b_q     <= sub ? ~b : b;
               // Subtraction is a + ~b + 1, so it forces the initial carry.
               carry_q <= sub | c_in;
               idx_q   <= '0;
            end
         end else begin
            sum_q[4*idx_q +: 4] <= add_s;
            carry_q             <= add_cout;
            idx_q               <= idx_q + 1'b1;
            if (last) begin
               done_q  <= 1'b1;
               c_out_q <= add_cout;
               // Signed overflow: the operand signs match but the result sign differs.
               ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[3] != a_q[WIDTH-1]);
            end
         end
      end
   end

endmodule
